// File: rtl/bcd_to_bin_if.sv
// Request/result bundle for the 3-digit BCD to 10-bit binary converter.
interface bcd_to_bin_if;
  logic [3:0] fdig;
  logic [3:0] sdig;
  logic [3:0] tdig;
  logic       start;
  logic [9:0] bin_d_out;
  logic       busy;
  logic       rdy;
  logic       err;
  logic       ovf;

  modport master (
    output fdig, sdig, tdig, start,
    input  bin_d_out, busy, rdy, err, ovf
  );

  modport slave (
    input  fdig, sdig, tdig, start,
    output bin_d_out, busy, rdy, err, ovf
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential reverse double-dabble: 3 BCD digits -> 10-bit binary.
// One conversion takes 23 cycles (capture, check, 10 x shift/adjust, done).
module bcd_to_bin (
  input  logic           clk,
  input  logic           rst_n,
  bcd_to_bin_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, CHECK, SHIFT, ADJUST, DONE} state_t;

  state_t      state;
  logic [21:0] work;     // {bcd[11:0], bin[9:0]}
  logic [3:0]  cnt;
  logic        err_q;
  logic [9:0]  bin_q;
  logic        busy_q;
  logic        rdy_q;
  logic        err_o;
  logic        ovf_q;

  // Undo the x2 carried into a BCD nibble by the right shift.
  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd8) ? n - 4'd3 : n;
  endfunction

  // Conversion FSM; all outputs registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      bin_q  <= '0;
      busy_q <= 1'b0;
      rdy_q  <= 1'b0;
      err_o  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdy_q <= 1'b0;
          if (bus.start) begin
            work   <= {bus.tdig, bus.sdig, bus.fdig, 10'd0};
            cnt    <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (work[21:18] > 4'd9 || work[17:14] > 4'd9 || work[13:10] > 4'd9) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work  <= {1'b0, work[21:1]};
          state <= ADJUST;
        end
        ADJUST: begin
          work[21:10] <= {adj(work[21:18]), adj(work[17:14]), adj(work[13:10])};
          cnt         <= cnt + 4'd1;
          state       <= (cnt == 4'd9) ? DONE : SHIFT;
        end
        DONE: begin
          bin_q  <= err_q ? 10'd0 : work[9:0];
          err_o  <= err_q;
          ovf_q  <= !err_q && (work[9:0] > 10'd255);
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          rdy_q  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.bin_d_out = bin_q;
  assign bus.busy      = busy_q;
  assign bus.rdy       = rdy_q;
  assign bus.err       = err_o;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: latency, results, error path, ignored
// restart, asynchronous reset abort and a full 000..999 back-to-back sweep.
module tb_bcd_to_bin;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  bcd_to_bin_if bus ();

  bcd_to_bin dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Pulse start with the given digits and check the whole transaction.
  // intf: at edge 5 present 9/9/9 with start high (must be ignored).
  task automatic conv(input string tag, input logic [3:0] t, input logic [3:0] s,
                      input logic [3:0] f, input logic [9:0] eb, input logic ee,
                      input int lat, input bit intf);
    int  n;
    bit  busy_ok;
    bit  rdy_early;
    @(negedge clk);
    bus.tdig = t; bus.sdig = s; bus.fdig = f; bus.start = 1'b1;
    @(posedge clk);                       // edge 0
    @(negedge clk);
    bus.start = 1'b0;
    n = 0; busy_ok = 1'b1; rdy_early = 1'b0;
    while (bus.rdy !== 1'b1 && n < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (intf && n == 4) begin
        bus.tdig = 4'd9; bus.sdig = 4'd9; bus.fdig = 4'd9; bus.start = 1'b1;
      end
      if (intf && n == 5) bus.start = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".busy_during"}, busy_ok, 1);
    chk({tag, ".bin"}, bus.bin_d_out, eb);
    chk({tag, ".err"}, bus.err, ee);
    chk({tag, ".ovf"}, bus.ovf, (!ee && eb > 10'd255) ? 1 : 0);
    chk({tag, ".busy_at_rdy"}, bus.busy, 0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.rdy !== 1'b0) rdy_early = 1'b1;
    end
    chk({tag, ".single_rdy"}, rdy_early, 0);
    chk({tag, ".bin_hold"}, bus.bin_d_out, eb);
  endtask

  initial begin
    int n;
    bit rdy_seen;
    bus.tdig = '0; bus.sdig = '0; bus.fdig = '0; bus.start = 1'b0;
    #12;
    chk("reset.bin", bus.bin_d_out, 0);
    chk("reset.busy", bus.busy, 0);
    chk("reset.rdy", bus.rdy, 0);
    chk("reset.err", bus.err, 0);
    chk("reset.ovf", bus.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    conv("c255", 4'd2, 4'd5, 4'd5, 10'd255, 1'b0, 22, 1'b0);
    conv("c999", 4'd9, 4'd9, 4'd9, 10'd999, 1'b0, 22, 1'b0);
    conv("c000", 4'd0, 4'd0, 4'd0, 10'd0,   1'b0, 22, 1'b0);
    conv("c128", 4'd1, 4'd2, 4'd8, 10'd128, 1'b0, 22, 1'b0);
    conv("c256", 4'd2, 4'd5, 4'd6, 10'd256, 1'b0, 22, 1'b0);
    conv("cerr", 4'd0, 4'hA, 4'd3, 10'd0,   1'b1, 2,  1'b0);
    conv("cerrf", 4'd1, 4'd2, 4'hF, 10'd0,  1'b1, 2,  1'b0);
    conv("c042", 4'd0, 4'd4, 4'd2, 10'd42,  1'b0, 22, 1'b0);
    conv("c456", 4'd4, 4'd5, 4'd6, 10'd456, 1'b0, 22, 1'b1);

    // Reset in the middle of a conversion: outputs clear without a clock.
    @(negedge clk);
    bus.tdig = 4'd7; bus.sdig = 4'd7; bus.fdig = 4'd7; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.bin", bus.bin_d_out, 0);
    chk("arst.busy", bus.busy, 0);
    chk("arst.rdy", bus.rdy, 0);
    rdy_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.rdy !== 1'b0) rdy_seen = 1'b1;
      if (k == 3) rst_n = 1'b1;
    end
    chk("arst.no_rdy", rdy_seen, 0);
    conv("c100", 4'd1, 4'd0, 4'd0, 10'd100, 1'b0, 22, 1'b0);

    // Back-to-back sweep with start held high.
    @(negedge clk);
    bus.start = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      bus.tdig = 4'(v / 100);
      bus.sdig = 4'((v / 10) % 10);
      bus.fdig = 4'(v % 10);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.rdy !== 1'b1 && n < 40);
      chk("sweep.period", n, 23);
      chk("sweep.bin", bus.bin_d_out, v);
      chk("sweep.ovf", bus.ovf, (v > 255) ? 1 : 0);
      if (n >= 40) break;
    end
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    chk("idle.busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameter: none; widths are fixed at 3 BCD digits in and 10 bits out.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 fdig  input  4  units BCD digit.
REQ-005 sdig  input  4  tens BCD digit.
REQ-006 tdig  input  4  hundreds BCD digit.
REQ-007 start  input  1  conversion request, level-sampled.
REQ-008 bin_d_out  output  10  binary result, 0..999.
REQ-009 busy  output  1  conversion in progress.
REQ-010 rdy  output  1  one-cycle result-valid pulse.
REQ-011 err  output  1  last request contained a digit >9.
REQ-012 ovf  output  1  last valid result >255, i.e. does not fit the 8-bit duty register.

Function
REQ-013 Algorithm SHALL be reverse double-dabble: 22-bit working register {bcd[11:0], bin[9:0]}, 10 shift/adjust iterations.
REQ-014 FSM states SHALL be IDLE, CHECK, SHIFT, ADJUST, DONE; any unused encoding returns to IDLE.
REQ-015 IDLE: on an edge with start=1, SHALL capture {tdig,sdig,fdig} into bcd, clear bin and iteration counter, set busy=1, go to CHECK.
REQ-016 IDLE with start=0 SHALL hold all outputs.
REQ-017 CHECK: if any captured digit >9, SHALL go to DONE with an error flag set internally; otherwise go to SHIFT.
REQ-018 SHIFT: working register SHALL shift right by 1 with 0 into the MSB; go to ADJUST.
REQ-019 ADJUST: for each of the 3 BCD nibbles independently, if nibble >=8 subtract 3 (4-bit, no borrow between nibbles); increment counter; go to DONE when counter was 9, else to SHIFT.
REQ-020 DONE: SHALL register bin_d_out (0 on error), err, ovf; pulse rdy=1 for exactly one cycle; clear busy; go to IDLE.
REQ-021 Latency (valid input) SHALL be: rdy high during the cycle following the 22nd rising edge counted from the edge that samples start (edge 0); error path: following edge 2.
REQ-022 start while busy=1 SHALL be ignored; captured digits SHALL NOT change mid-conversion, even if fdig/sdig/tdig change.
REQ-023 start held high continuously SHALL launch a new conversion on the edge following DONE (back-to-back throughput 23 cycles).
REQ-024 bin_d_out, err, ovf SHALL hold their values from DONE until the next DONE; they SHALL NOT glitch during conversion.
REQ-025 ovf SHALL be 1 iff err=0 and bin_d_out >255; on error ovf=0.
REQ-026 rdy and busy SHALL never be high in the same cycle.

Reset
REQ-027 rst_n low SHALL immediately, without a clock, force state=IDLE, bin_d_out=0, busy=0, rdy=0, err=0, ovf=0, and clear the working register and counter.
REQ-028 Reset asserted mid-conversion SHALL abort the conversion with no rdy pulse; the first start after rst_n rises SHALL convert normally.
REQ-029 After rst_n deasserts, start SHALL be sampled on the first rising edge.

Verification
REQ-030 tdig=2,sdig=5,fdig=5, start pulse -> rdy at edge 22, bin_d_out=255, ovf=0, err=0, busy high edges 1..21.
REQ-031 9/9/9 -> bin_d_out=999, ovf=1; then 0/0/0 -> bin_d_out=0, ovf=0; then 1/2/8 -> 128.
REQ-032 tdig=0,sdig=0xA,fdig=3 -> rdy at edge 2, err=1, bin_d_out=0, ovf=0; next valid request clears err.
REQ-033 Start 4/5/6, change digits to 9/9/9 and pulse start at edge 5 -> result 456, single rdy pulse, second start ignored.
REQ-034 Start 7/7/7, assert rst_n low at edge 10 between clock edges -> outputs 0 asynchronously, no rdy; re-request 1/0/0 -> 100 at edge 22.
REQ-035 Exhaustive sweep 000..999 with start held high -> every result equals the decimal value, ovf correct, one rdy per 23 cycles.
